dma_pingpong_engine: RTL and testbench

Parametrised two-bank (ping-pong) DMA engine. It moves a programmed number of words between a CPU-side stream of width CPU_W and a memory-side stream of width MEM_W, in either direction. It performs the width conversion, a memory address/length handshake, and a partial-bank flush at end of transfer. It sits between the CPU data port and the memory data port; one descriptor is active at a time and completion is signalled by a one-cycle done pulse.

---
 rtl/dma_pingpong_engine.sv | 213 +++++++++++++++++++++
 tb/tb_dma_pingpong_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_pingpong_engine.sv
// Two-bank ping-pong DMA engine moving CPU_W words between a CPU stream and a
// MEM_W memory stream in either direction, with address handshake and partial flush.
module dma_pingpong_engine #(
  parameter int CPU_W  = 8,
  parameter int MEM_W  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_dir,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              mem_addr_valid,
  input  logic              mem_addr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  input  logic              cpu_in_valid,
  output logic              cpu_in_ready,
  input  logic [CPU_W-1:0]  cpu_in_data,
  output logic              cpu_out_valid,
  input  logic              cpu_out_ready,
  output logic [CPU_W-1:0]  cpu_out_data,
  input  logic              mem_in_valid,
  output logic              mem_in_ready,
  input  logic [MEM_W-1:0]  mem_in_data,
  output logic              mem_out_valid,
  input  logic              mem_out_ready,
  output logic [MEM_W-1:0]  mem_out_data,
  output logic              busy,
  output logic              done
);

  localparam int R     = CPU_W / MEM_W;
  localparam int SUB_W = (R > 1) ? $clog2(R) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ADDR, XFER, DONE} state_t;

  state_t           state;
  logic             dir;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] in_cnt;
  logic [LEN_W-1:0] out_cnt;
  logic [SUB_W-1:0] in_sub;
  logic [SUB_W-1:0] out_sub;
  logic [CPU_W-1:0] asm_word;
  logic [CPU_W-1:0] asm_next;
  logic             fill_sel;
  logic             fill_sealed;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] rd_ptr;

  logic [CPU_W-1:0] bank_mem [2][DEPTH];

  logic             xfer;
  logic             prod_ready;
  logic             cons_avail;
  logic             prod_fire;
  logic             prod_word;
  logic             cons_fire;
  logic             cons_word;
  logic             drain_empty;
  logic             swap;
  logic [CPU_W-1:0] wr_word;
  logic [CPU_W-1:0] drain_word;
  logic [CPU_W-1:0] drain_shift;

  assign xfer        = (state == XFER);
  assign prod_ready  = xfer && !fill_sealed && (in_cnt < len);
  assign cons_avail  = xfer && (rd_ptr < drain_cnt);
  assign drain_empty = (rd_ptr == drain_cnt);
  assign swap        = xfer && fill_sealed && drain_empty;

  assign cpu_in_ready  = prod_ready &&  dir;
  assign mem_in_ready  = prod_ready && !dir;
  assign mem_out_valid = cons_avail &&  dir;
  assign cpu_out_valid = cons_avail && !dir;

  assign prod_fire = dir ? (cpu_in_valid && cpu_in_ready) : (mem_in_valid && mem_in_ready);
  assign prod_word = prod_fire && (dir || (in_sub == SUB_W'(R - 1)));
  assign cons_fire = dir ? (mem_out_valid && mem_out_ready) : (cpu_out_valid && cpu_out_ready);
  assign cons_word = cons_fire && (!dir || (out_sub == SUB_W'(R - 1)));

  // Sub-beats arrive least-significant first; slot the current one into the word.
  always_comb begin
    int in_off;
    asm_next = asm_word;
    in_off   = int'(in_sub) * MEM_W;
    asm_next[in_off +: MEM_W] = mem_in_data;
  end

  assign wr_word     = dir ? cpu_in_data : asm_next;
  assign drain_word  = bank_mem[~fill_sel][rd_ptr[PTR_W-1:0]];
  assign drain_shift = drain_word >> (int'(out_sub) * MEM_W);

  // Data outputs read as zero whenever their stream is idle.
  assign mem_out_data = mem_out_valid ? drain_shift[MEM_W-1:0] : '0;
  assign cpu_out_data = cpu_out_valid ? drain_word : '0;

  always_ff @(posedge clk) begin
    if (prod_word) begin
      bank_mem[fill_sel][fill_cnt[PTR_W-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      cfg_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_addr_valid <= 1'b0;
      mem_addr       <= '0;
      mem_len        <= '0;
      dir            <= 1'b0;
      len            <= '0;
      in_cnt         <= '0;
      out_cnt        <= '0;
      in_sub         <= '0;
      out_sub        <= '0;
      asm_word       <= '0;
      fill_sel       <= 1'b0;
      fill_sealed    <= 1'b0;
      fill_cnt       <= '0;
      drain_cnt      <= '0;
      rd_ptr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            dir         <= cfg_dir;
            len         <= cfg_len;
            mem_addr    <= cfg_addr;
            mem_len     <= cfg_len * LEN_W'(R);
            in_cnt      <= '0;
            out_cnt     <= '0;
            in_sub      <= '0;
            out_sub     <= '0;
            fill_sel    <= 1'b0;
            fill_sealed <= 1'b0;
            fill_cnt    <= '0;
            drain_cnt   <= '0;
            rd_ptr      <= '0;
            cfg_ready   <= 1'b0;
            busy        <= 1'b1;
            if (cfg_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state          <= ADDR;
              mem_addr_valid <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (mem_addr_ready) begin
            mem_addr_valid <= 1'b0;
            state          <= XFER;
          end
        end
        XFER: begin
          if (cons_word && ((out_cnt + 1'b1) == len)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Handshakes are gated by XFER, so these never collide with IDLE's clears.
      if (prod_fire && !dir) begin
        in_sub   <= (in_sub == SUB_W'(R - 1)) ? '0 : in_sub + 1'b1;
        asm_word <= asm_next;
      end
      if (prod_word) begin
        in_cnt   <= in_cnt + 1'b1;
        fill_cnt <= fill_cnt + 1'b1;
        if ((fill_cnt == CNT_W'(DEPTH - 1)) || ((in_cnt + 1'b1) == len)) begin
          fill_sealed <= 1'b1;
        end
      end
      if (cons_fire && dir) begin
        out_sub <= (out_sub == SUB_W'(R - 1)) ? '0 : out_sub + 1'b1;
      end
      if (cons_word) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_cnt <= out_cnt + 1'b1;
      end
      // Swap needs a sealed fill bank and an empty drain bank, so it never
      // coincides with a producer or consumer word.
      if (swap) begin
        fill_sel    <= ~fill_sel;
        drain_cnt   <= fill_cnt;
        fill_cnt    <= '0;
        fill_sealed <= 1'b0;
        rd_ptr      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dma_pingpong_engine.sv
// Directed bench for dma_pingpong_engine: both directions, partial flush,
// back-pressure, zero-length descriptors and mid-transfer reset.
module tb_dma_pingpong_engine;

  localparam int CPU_W  = 8;
  localparam int MEM_W  = 4;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cfg_valid, cfg_ready, cfg_dir;
  logic [ADDR_W-1:0] cfg_addr;
  logic [LEN_W-1:0]  cfg_len;
  logic              mem_addr_valid, mem_addr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [LEN_W-1:0]  mem_len;
  logic              cpu_in_valid, cpu_in_ready;
  logic [CPU_W-1:0]  cpu_in_data;
  logic              cpu_out_valid, cpu_out_ready;
  logic [CPU_W-1:0]  cpu_out_data;
  logic              mem_in_valid, mem_in_ready;
  logic [MEM_W-1:0]  mem_in_data;
  logic              mem_out_valid, mem_out_ready;
  logic [MEM_W-1:0]  mem_out_data;
  logic              busy, done;

  always #5 clk = ~clk;

  dma_pingpong_engine #(
    .CPU_W(CPU_W), .MEM_W(MEM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_dir(cfg_dir),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready),
    .mem_addr(mem_addr), .mem_len(mem_len),
    .cpu_in_valid(cpu_in_valid), .cpu_in_ready(cpu_in_ready), .cpu_in_data(cpu_in_data),
    .cpu_out_valid(cpu_out_valid), .cpu_out_ready(cpu_out_ready), .cpu_out_data(cpu_out_data),
    .mem_in_valid(mem_in_valid), .mem_in_ready(mem_in_ready), .mem_in_data(mem_in_data),
    .mem_out_valid(mem_out_valid), .mem_out_ready(mem_out_ready), .mem_out_data(mem_out_data),
    .busy(busy), .done(done)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] cpu_src[$];
  logic [7:0] cpu_exp[$];
  logic [3:0] mem_src[$];
  logic [3:0] mem_exp[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    cfg_valid      = 1'b0;
    cfg_dir        = 1'b0;
    cfg_addr       = '0;
    cfg_len        = '0;
    mem_addr_ready = 1'b0;
    cpu_in_valid   = 1'b0;
    cpu_in_data    = '0;
    cpu_out_ready  = 1'b0;
    mem_in_valid   = 1'b0;
    mem_in_data    = '0;
    mem_out_ready  = 1'b0;
  endtask

  // Runs one descriptor against the source/expected queues; abort_words >= 0
  // pulls reset once that many producer words have been accepted.
  task automatic applyStimulus(input bit d, input int n, input logic [31:0] a,
                               input int addr_delay, input bit stall,
                               input int abort_words, input string name);
    int  cyc, words_in, words_out, subs_in, subs_out, done_cnt, max_occ, dcount;
    bit  p_valid, p_fire, c_fire, c_ready, aborted;
    cyc = 0; words_in = 0; words_out = 0; subs_in = 0; subs_out = 0;
    done_cnt = 0; max_occ = 0; aborted = 1'b0;

    cfg_valid = 1'b1; cfg_dir = d; cfg_addr = a; cfg_len = LEN_W'(n);
    checkOutput({name, ":cfg_ready_idle"}, 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0; cfg_dir = ~d; cfg_addr = '0; cfg_len = '0;
    checkOutput({name, ":addr_valid"}, 64'(mem_addr_valid), 64'd1);
    checkOutput({name, ":mem_addr"}, 64'(mem_addr), 64'(a));
    checkOutput({name, ":mem_len"}, 64'(mem_len), 64'(n * 2));
    checkOutput({name, ":busy"}, 64'(busy), 64'd1);
    checkOutput({name, ":cfg_ready_busy"}, 64'(cfg_ready), 64'd0);

    // Offer the first producer beat during the address phase; it must wait.
    p_valid = 1'b1;
    if (d) begin cpu_in_valid = 1'b1; cpu_in_data = cpu_src[0]; end
    else   begin mem_in_valid = 1'b1; mem_in_data = mem_src[0]; end
    for (int i = 0; i < addr_delay; i++) begin
      checkOutput({name, ":addr_hold"}, 64'(mem_addr_valid), 64'd1);
      checkOutput({name, ":no_ready_in_addr"}, 64'(cpu_in_ready | mem_in_ready), 64'd0);
      tick();
    end
    mem_addr_ready = 1'b1;
    tick();
    mem_addr_ready = 1'b0;
    checkOutput({name, ":addr_dropped"}, 64'(mem_addr_valid), 64'd0);

    while (((d ? mem_exp.size() : cpu_exp.size()) > 0) && cyc < 3000) begin
      if (abort_words >= 0 && words_in >= abort_words) begin
        aborted = 1'b1;
        break;
      end
      if (!p_valid && (d ? cpu_src.size() > 0 : mem_src.size() > 0))
        p_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (d) begin
        cpu_in_valid = p_valid;
        cpu_in_data  = p_valid ? cpu_src[0] : '0;
      end else begin
        mem_in_valid = p_valid;
        mem_in_data  = p_valid ? mem_src[0] : '0;
      end
      c_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (d) mem_out_ready = c_ready; else cpu_out_ready = c_ready;
      if (stall) begin cfg_valid = 1'b1; cfg_len = 1; end

      p_fire = p_valid && (d ? cpu_in_ready : mem_in_ready);
      c_fire = c_ready && (d ? mem_out_valid : cpu_out_valid);
      if (c_fire) begin
        if (d) begin
          checkOutput({name, ":mem_out_data"}, 64'(mem_out_data), 64'(mem_exp[0]));
          void'(mem_exp.pop_front());
          subs_out++;
          if (subs_out % 2 == 0) words_out++;
        end else begin
          checkOutput({name, ":cpu_out_data"}, 64'(cpu_out_data), 64'(cpu_exp[0]));
          void'(cpu_exp.pop_front());
          words_out++;
        end
      end
      if (p_fire) begin
        if (d) begin
          void'(cpu_src.pop_front());
          words_in++;
        end else begin
          void'(mem_src.pop_front());
          subs_in++;
          if (subs_in % 2 == 0) words_in++;
        end
        p_valid = 1'b0;
      end
      if (words_in - words_out > max_occ) max_occ = words_in - words_out;
      if (done) done_cnt++;
      tick();
      cyc++;
    end
    clearInputs();

    if (aborted) begin
      resetn = 1'b0;
      tick();
      checkOutput({name, ":abort_busy"}, 64'(busy), 64'd0);
      checkOutput({name, ":abort_cfg_ready"}, 64'(cfg_ready), 64'd1);
      checkOutput({name, ":abort_valids"},
                  64'(mem_out_valid | cpu_out_valid | mem_addr_valid | cpu_in_ready | mem_in_ready), 64'd0);
      tick();
      resetn = 1'b1;
      dcount = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (done) dcount++;
      end
      checkOutput({name, ":abort_no_done"}, 64'(dcount + done_cnt), 64'd0);
      checkOutput({name, ":abort_idle"}, 64'(cfg_ready), 64'd1);
      return;
    end

    checkOutput({name, ":beats_left"}, 64'(d ? mem_exp.size() : cpu_exp.size()), 64'd0);
    checkOutput({name, ":occupancy_ok"}, 64'(max_occ <= 2 * DEPTH), 64'd1);
    checkOutput({name, ":done_pulse"}, 64'(done), 64'd1);
    checkOutput({name, ":cfg_ready_in_done"}, 64'(cfg_ready), 64'd0);
    dcount = done_cnt + int'(done);
    tick();
    checkOutput({name, ":done_cleared"}, 64'(done), 64'd0);
    checkOutput({name, ":cfg_ready_back"}, 64'(cfg_ready), 64'd1);
    checkOutput({name, ":busy_cleared"}, 64'(busy), 64'd0);
    checkOutput({name, ":done_pulses"}, 64'(dcount), 64'd1);
  endtask

  initial begin
    logic [7:0] t1_words [8];
    logic [7:0] t6_words [4];
    logic [3:0] t6_nibs  [8];
    logic [3:0] t5_nibs  [6];
    logic [7:0] t5_words [3];
    t1_words = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F};
    t6_words = '{8'hA5, 8'h3C, 8'h7E, 8'h01};
    t6_nibs  = '{4'h5, 4'hA, 4'hC, 4'h3, 4'hE, 4'h7, 4'h1, 4'h0};
    t5_nibs  = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4};
    t5_words = '{8'h89, 8'h67, 8'h45};

    clearInputs();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'($urandom); cfg_dir = 1'($urandom); cfg_addr = $urandom; cfg_len = $urandom;
      mem_addr_ready = 1'($urandom); cpu_in_valid = 1'($urandom); cpu_in_data = 8'($urandom);
      cpu_out_ready = 1'($urandom); mem_in_valid = 1'($urandom); mem_in_data = 4'($urandom);
      mem_out_ready = 1'($urandom);
      tick();
    end
    checkOutput("reset:cfg_ready", 64'(cfg_ready), 64'd1);
    checkOutput("reset:busy", 64'(busy), 64'd0);
    checkOutput("reset:done", 64'(done), 64'd0);
    checkOutput("reset:valids",
                64'(mem_addr_valid | cpu_out_valid | mem_out_valid | cpu_in_ready | mem_in_ready), 64'd0);
    checkOutput("reset:mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset:mem_len", 64'(mem_len), 64'd0);
    checkOutput("reset:out_data", 64'({cpu_out_data, mem_out_data}), 64'd0);
    clearInputs();
    resetn = 1'b1;
    tick();

    // CPU->MEM, one full bank, delayed address ready.
    for (int i = 0; i < 8; i++) cpu_src.push_back(t1_words[i]);
    for (int k = 0; k < 16; k++) mem_exp.push_back(4'((k + 1) & 15));
    applyStimulus(1'b1, 8, 32'h1000_0040, 2, 1'b0, -1, "c2m_len8");

    // MEM->CPU, two full banks plus a 3-word flush.
    for (int k = 0; k < 38; k++) mem_src.push_back(4'(k & 15));
    for (int i = 0; i < 19; i++) cpu_exp.push_back(8'((((2 * i + 1) & 15) << 4) | ((2 * i) & 15)));
    applyStimulus(1'b0, 19, 32'h2000_0000, 0, 1'b0, -1, "m2c_len19");

    // MEM->CPU under random gaps and stray cfg_valid.
    for (int k = 0; k < 128; k++) mem_src.push_back(4'(k & 15));
    for (int i = 0; i < 64; i++) cpu_exp.push_back(8'((((2 * i + 1) & 15) << 4) | ((2 * i) & 15)));
    applyStimulus(1'b0, 64, 32'h3000_0100, 1, 1'b1, -1, "m2c_stall64");

    // Zero-length descriptor, then a normal one.
    cfg_valid = 1'b1; cfg_dir = 1'b1; cfg_addr = 32'hDEAD_0000; cfg_len = '0;
    tick();
    clearInputs();
    checkOutput("len0:done", 64'(done), 64'd1);
    checkOutput("len0:no_addr", 64'(mem_addr_valid), 64'd0);
    tick();
    checkOutput("len0:done_cleared", 64'(done), 64'd0);
    checkOutput("len0:cfg_ready", 64'(cfg_ready), 64'd1);
    checkOutput("len0:still_no_addr", 64'(mem_addr_valid), 64'd0);
    for (int i = 0; i < 6; i++) mem_src.push_back(t5_nibs[i]);
    for (int i = 0; i < 3; i++) cpu_exp.push_back(t5_words[i]);
    applyStimulus(1'b0, 3, 32'h0000_0010, 0, 1'b0, -1, "after_len0");

    // Reset at word 5 of a 20-word transfer, then a fresh 4-word one.
    for (int i = 0; i < 20; i++) cpu_src.push_back(8'(i * 7 + 3));
    for (int i = 0; i < 20; i++) begin
      mem_exp.push_back(4'((i * 7 + 3) & 15));
      mem_exp.push_back(4'(((i * 7 + 3) >> 4) & 15));
    end
    applyStimulus(1'b1, 20, 32'h4000_0000, 0, 1'b0, 5, "abort_len20");
    cpu_src.delete(); mem_exp.delete(); mem_src.delete(); cpu_exp.delete();
    for (int i = 0; i < 4; i++) cpu_src.push_back(t6_words[i]);
    for (int i = 0; i < 8; i++) mem_exp.push_back(t6_nibs[i]);
    applyStimulus(1'b1, 4, 32'h5000_0000, 1, 1'b0, -1, "post_abort_len4");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
